control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that drives every control input of the CPU datapath, so it is the other end of the datapath's control interface.
- Steps through a three-cycle instruction fetch, decodes the opcode in IR[31:27], then runs a fixed per-opcode execute sequence before returning to fetch.
- Sits beside the datapath. Its only input from the datapath is the IR value.

Parameters:
- OPW, 5, opcode field width (IR[31:27]).
- SW, 4, state register width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  asynchronous, active-high reset
- ir  in  32  instruction register contents from the datapath
- pci, pco, iri, iro, mari, maro, mdri, mdro  out  1 each  register in/out strobes
- mem_read, mem_write  out  1 each  memory strobes; mem_read also selects the MDR input mux
- hii, hio, loi, loo, ryi, ryo, rzi, rzo  out  1 each  HI/LO/Y/Z strobes
- csigno  out  1  sign-extended C field onto the bus
- gra, grb, grc, rin, rout, baout  out  1 each  select-and-encode controls
- incpc  out  1  PC increment request to the PC logic
- run  out  1  1 = executing, 0 = halted
- state  out  SW  current state code, for debug

Behaviour:
- States and codes: T0=0 … T7=7, HALT=8.
- Opcodes:
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110
  - addi=01100, nop=11010, halt=11011
  - Every other opcode behaves as nop.
- Reset:
  - clear high forces state=T0 asynchronously, including mid-instruction.
  - While clear is high, all strobes are 0 and run=1.
  - After release, the first rising edge executes T0.
- Outputs are decoded combinationally from state and ir[31:27] only (Moore). Unlisted outputs are 0 in every state. hii, hio, loi, loo, iro, maro, ryo are always 0 (reserved).
- Fetch (all opcodes):
  - T0: pco, mari, incpc
  - T1: mem_read, mdri
  - T2: mdro, iri
  - Decode uses ir in T3 onward, because IR loads on the T2 edge.
- add/sub/and/or:
  - T3: grb, rout, ryi
  - T4: grc, rout, rzi
  - T5: gra, rin, rzo
  - Next state T0. The ALU op comes from IR directly.
- addi:
  - T3: grb, rout, ryi
  - T4: csigno, rzi
  - T5: gra, rin, rzo
  - Next state T0.
- ldi:
  - T3: grb, baout, ryi
  - T4: csigno, rzi
  - T5: gra, rin, rzo
  - Next state T0.
- ld:
  - T3: grb, baout, ryi
  - T4: csigno, rzi
  - T5: rzo, mari
  - T6: mem_read, mdri
  - T7: mdro, gra, rin
  - Next state T0.
- st:
  - T3–T5 as ld.
  - T6: gra, rout, mdri, with mem_read=0 so the MDR takes the bus.
  - T7: mem_write
  - Next state T0.
- nop and unknown opcodes: T3 asserts no strobes, then T0.
- halt: T3 goes to HALT. HALT asserts no strobes, run=0, and holds until clear.
- One-hot rules, checked every cycle:
  - At most one bus driver: pco, mdro, rzo, csigno, or (rout|baout).
  - At most one of gra/grb/grc.
  - mem_read and mem_write are never asserted together.
- Instruction latency (T0 to next T0): 6 cycles for ALU, addi and ldi; 8 for ld and st; 4 for nop.

Test Plan:
- Reset mid-op: ld in progress, clear pulsed during T6 → state=0 immediately and all strobes 0. After release, the next edge shows pco=mari=incpc=1.
- Fetch plus add: IR=0x18000000 (opcode 00011) → T0–T2 strobes as specified, then T3 {grb,rout,ryi}, T4 {grc,rout,rzi}, T5 {gra,rin,rzo}, back to T0 on cycle 6.
- ld versus st: opcode 00000 gives T6 {mem_read,mdri} and T7 {mdro,gra,rin}. Opcode 00010 gives T6 {gra,rout,mdri} with mem_read=0, and T7 {mem_write} only. Both return to T0 after 8 cycles.
- addi/ldi: opcode 01100 gives T3 {grb,rout,ryi}; opcode 00001 gives T3 {grb,baout,ryi}. Both give T4 {csigno,rzi}.
- halt: opcode 11011 → state=8 and run=0 from T3 onward; 20 further clocks give no strobes. Asserting clear returns run=1 and state=0.
- Unknown opcode 11111 → identical to nop: 4-cycle loop with an empty T3. A bus-driver one-hot assertion is active across a random opcode stream of 1000 instructions.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control interface between the hardwired sequencer and the CPU datapath.
// Carries the IR value from the datapath and every control strobe going back.
//   master : sequencer side (drives strobes, run, state; reads ir)
//   slave  : datapath side (drives ir; reads strobes)
interface control_sequencer_if #(
  parameter int SW = 4
);
  logic [31:0]   ir;
  logic          pci, pco, iri, iro, mari, maro, mdri, mdro;
  logic          mem_read, mem_write;
  logic          hii, hio, loi, loo, ryi, ryo, rzi, rzo;
  logic          csigno;
  logic          gra, grb, grc, rin, rout, baout;
  logic          incpc;
  logic          run;
  logic [SW-1:0] state;

  modport master (
    input  ir,
    output pci, pco, iri, iro, mari, maro, mdri, mdro,
    output mem_read, mem_write,
    output hii, hio, loi, loo, ryi, ryo, rzi, rzo,
    output csigno,
    output gra, grb, grc, rin, rout, baout,
    output incpc, run, state
  );

  modport slave (
    output ir,
    input  pci, pco, iri, iro, mari, maro, mdri, mdro,
    input  mem_read, mem_write,
    input  hii, hio, loi, loo, ryi, ryo, rzi, rzo,
    input  csigno,
    input  gra, grb, grc, rin, rout, baout,
    input  incpc, run, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the CPU datapath.
// Runs a three-cycle fetch (T0-T2), decodes ir[31:27] from T3 onward, then a
// fixed per-opcode execute sequence before returning to T0. The halt opcode
// parks the machine in HALT until clear.
//   clock : system clock, rising edge
//   clear : asynchronous active-high reset to T0; strobes forced low while high
//   bus   : control interface (ir in; strobes, run, state out)
module control_sequencer #(
  parameter int OPW = 5,
  parameter int SW  = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [SW-1:0] {
    T0   = SW'(0),
    T1   = SW'(1),
    T2   = SW'(2),
    T3   = SW'(3),
    T4   = SW'(4),
    T5   = SW'(5),
    T6   = SW'(6),
    T7   = SW'(7),
    HALT = SW'(8)
  } state_t;

  typedef enum logic [OPW-1:0] {
    OP_LD   = OPW'(5'b00000),
    OP_LDI  = OPW'(5'b00001),
    OP_ST   = OPW'(5'b00010),
    OP_ADD  = OPW'(5'b00011),
    OP_SUB  = OPW'(5'b00100),
    OP_AND  = OPW'(5'b00101),
    OP_OR   = OPW'(5'b00110),
    OP_ADDI = OPW'(5'b01100),
    OP_NOP  = OPW'(5'b11010),
    OP_HALT = OPW'(5'b11011)
  } opcode_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] opc;
  logic           is_alu, is_imm, is_mem;
  logic           unused_ir_bits;

  assign opc            = bus.ir[31 -: OPW];
  assign unused_ir_bits = ^bus.ir[31-OPW:0];

  assign is_alu = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_OR);
  // addi and ldi share T4/T5 with the ALU group but source C from the immediate
  assign is_imm = (opc == OP_ADDI) || (opc == OP_LDI);
  assign is_mem = (opc == OP_LD) || (opc == OP_ST);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= T0;
    else       state_q <= state_d;
  end

  assign bus.state = state_q;

  always_comb begin
    state_d       = state_q;
    bus.pci       = 1'b0;
    bus.pco       = 1'b0;
    bus.iri       = 1'b0;
    bus.iro       = 1'b0;
    bus.mari      = 1'b0;
    bus.maro      = 1'b0;
    bus.mdri      = 1'b0;
    bus.mdro      = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hii       = 1'b0;
    bus.hio       = 1'b0;
    bus.loi       = 1'b0;
    bus.loo       = 1'b0;
    bus.ryi       = 1'b0;
    bus.ryo       = 1'b0;
    bus.rzi       = 1'b0;
    bus.rzo       = 1'b0;
    bus.csigno    = 1'b0;
    bus.gra       = 1'b0;
    bus.grb       = 1'b0;
    bus.grc       = 1'b0;
    bus.rin       = 1'b0;
    bus.rout      = 1'b0;
    bus.baout     = 1'b0;
    bus.incpc     = 1'b0;
    bus.run       = (state_q != HALT);

    // Strobe decode is suppressed while clear is asserted so the datapath sees
    // a quiet control bus during reset, even though state already reads T0.
    if (!clear) begin
      unique case (state_q)
        T0: begin
          bus.pco   = 1'b1;
          bus.mari  = 1'b1;
          bus.incpc = 1'b1;
          state_d   = T1;
        end
        T1: begin
          bus.mem_read = 1'b1;
          bus.mdri     = 1'b1;
          state_d      = T2;
        end
        T2: begin
          bus.mdro = 1'b1;
          bus.iri  = 1'b1;
          state_d  = T3;
        end
        T3: begin
          if (is_alu || (opc == OP_ADDI)) begin
            bus.grb  = 1'b1;
            bus.rout = 1'b1;
            bus.ryi  = 1'b1;
            state_d  = T4;
          end else if ((opc == OP_LDI) || is_mem) begin
            bus.grb   = 1'b1;
            bus.baout = 1'b1;
            bus.ryi   = 1'b1;
            state_d   = T4;
          end else if (opc == OP_HALT) begin
            state_d = HALT;
          end else begin
            state_d = T0;
          end
        end
        T4: begin
          if (is_alu) begin
            bus.grc  = 1'b1;
            bus.rout = 1'b1;
            bus.rzi  = 1'b1;
            state_d  = T5;
          end else if (is_imm || is_mem) begin
            bus.csigno = 1'b1;
            bus.rzi    = 1'b1;
            state_d    = T5;
          end else begin
            state_d = T0;
          end
        end
        T5: begin
          if (is_mem) begin
            bus.rzo  = 1'b1;
            bus.mari = 1'b1;
            state_d  = T6;
          end else if (is_alu || is_imm) begin
            bus.gra = 1'b1;
            bus.rin = 1'b1;
            bus.rzo = 1'b1;
            state_d = T0;
          end else begin
            state_d = T0;
          end
        end
        T6: begin
          if (opc == OP_LD) begin
            bus.mem_read = 1'b1;
            bus.mdri     = 1'b1;
            state_d      = T7;
          end else if (opc == OP_ST) begin
            // mem_read stays low so the MDR input mux selects the bus
            bus.gra  = 1'b1;
            bus.rout = 1'b1;
            bus.mdri = 1'b1;
            state_d  = T7;
          end else begin
            state_d = T0;
          end
        end
        T7: begin
          if (opc == OP_LD) begin
            bus.mdro = 1'b1;
            bus.gra  = 1'b1;
            bus.rin  = 1'b1;
          end else if (opc == OP_ST) begin
            bus.mem_write = 1'b1;
          end
          state_d = T0;
        end
        HALT: state_d = HALT;
        default: state_d = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic clock;
  logic clear;

  control_sequencer_if #(.SW(4)) cs_if ();

  control_sequencer #(.OPW(5), .SW(4)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (cs_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  localparam logic [25:0] B_PCO   = 26'd1 << 24;
  localparam logic [25:0] B_IRI   = 26'd1 << 23;
  localparam logic [25:0] B_MARI  = 26'd1 << 21;
  localparam logic [25:0] B_MDRI  = 26'd1 << 19;
  localparam logic [25:0] B_MDRO  = 26'd1 << 18;
  localparam logic [25:0] B_MRD   = 26'd1 << 17;
  localparam logic [25:0] B_MWR   = 26'd1 << 16;
  localparam logic [25:0] B_RYI   = 26'd1 << 11;
  localparam logic [25:0] B_RZI   = 26'd1 << 9;
  localparam logic [25:0] B_RZO   = 26'd1 << 8;
  localparam logic [25:0] B_CSO   = 26'd1 << 7;
  localparam logic [25:0] B_GRA   = 26'd1 << 6;
  localparam logic [25:0] B_GRB   = 26'd1 << 5;
  localparam logic [25:0] B_GRC   = 26'd1 << 4;
  localparam logic [25:0] B_RIN   = 26'd1 << 3;
  localparam logic [25:0] B_ROUT  = 26'd1 << 2;
  localparam logic [25:0] B_BAOUT = 26'd1 << 1;
  localparam logic [25:0] B_INCPC = 26'd1 << 0;

  localparam logic [25:0] F0 = B_PCO | B_MARI | B_INCPC;
  localparam logic [25:0] F1 = B_MRD | B_MDRI;
  localparam logic [25:0] F2 = B_MDRO | B_IRI;

  function automatic logic [25:0] strobes();
    return {cs_if.pci, cs_if.pco, cs_if.iri, cs_if.iro, cs_if.mari, cs_if.maro,
            cs_if.mdri, cs_if.mdro, cs_if.mem_read, cs_if.mem_write,
            cs_if.hii, cs_if.hio, cs_if.loi, cs_if.loo, cs_if.ryi, cs_if.ryo,
            cs_if.rzi, cs_if.rzo, cs_if.csigno, cs_if.gra, cs_if.grb, cs_if.grc,
            cs_if.rin, cs_if.rout, cs_if.baout, cs_if.incpc};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns the sequencer to T0 between scenarios; no clock edge is crossed.
  task automatic restart();
    clear = 1'b1;
    #1;
    clear = 1'b0;
    #1;
  endtask

  always @(posedge clock) begin
    if (!clear) begin
      assert ($onehot0({cs_if.pco, cs_if.mdro, cs_if.rzo, cs_if.csigno, cs_if.rout | cs_if.baout}))
        else $error("FAIL bus_driver_assert strobes=%b", strobes());
      assert ($onehot0({cs_if.gra, cs_if.grb, cs_if.grc}))
        else $error("FAIL gr_assert strobes=%b", strobes());
      assert (!(cs_if.mem_read && cs_if.mem_write))
        else $error("FAIL mem_assert strobes=%b", strobes());
    end
  end

  task automatic test_reset();
    // clear still high from power-up
    ntotal++;
    if (cs_if.state !== 4'd0 || strobes() !== 26'd0 || cs_if.run !== 1'b1)
      $display("FAIL reset_hold state=%0d strobes=%b run=%b required state=0 strobes=0 run=1",
               cs_if.state, strobes(), cs_if.run);
    else npass++;

    cs_if.ir = 32'h0000_0000;
    tick();
    for (int unsigned i = 0; i < 6; i++) tick();
    ntotal++;
    if (cs_if.state !== 4'd0)
      $display("FAIL reset_no_advance state=%0d required 0", cs_if.state);
    else npass++;

    // ld running, reach T6 then pulse clear mid-instruction
    clear = 1'b0;
    #1;
    for (int unsigned i = 0; i < 6; i++) tick();
    ntotal++;
    if (cs_if.state !== 4'd6)
      $display("FAIL reset_reach_t6 state=%0d required 6", cs_if.state);
    else npass++;

    clear = 1'b1;
    #1;
    ntotal++;
    if (cs_if.state !== 4'd0 || strobes() !== 26'd0 || cs_if.run !== 1'b1)
      $display("FAIL reset_mid_op state=%0d strobes=%b run=%b required state=0 strobes=0 run=1",
               cs_if.state, strobes(), cs_if.run);
    else npass++;

    clear = 1'b0;
    #1;
    ntotal++;
    if (cs_if.state !== 4'd0 || strobes() !== F0)
      $display("FAIL reset_release_t0 state=%0d strobes=%b required state=0 strobes=%b",
               cs_if.state, strobes(), F0);
    else npass++;

    tick();
    ntotal++;
    if (cs_if.state !== 4'd1 || strobes() !== F1)
      $display("FAIL reset_first_edge state=%0d strobes=%b required state=1 strobes=%b",
               cs_if.state, strobes(), F1);
    else npass++;
  endtask

  task automatic test_add();
    logic [25:0] exp [6];
    exp = '{F0, F1, F2, B_GRB | B_ROUT | B_RYI, B_GRC | B_ROUT | B_RZI, B_GRA | B_RIN | B_RZO};
    restart();
    cs_if.ir = 32'h1800_0000;
    for (int unsigned i = 0; i < 6; i++) begin
      ntotal++;
      if (cs_if.state !== 4'(i) || strobes() !== exp[i])
        $display("FAIL add_t%0d state=%0d strobes=%b required state=%0d strobes=%b",
                 i, cs_if.state, strobes(), i, exp[i]);
      else npass++;
      tick();
    end
    ntotal++;
    if (cs_if.state !== 4'd0 || strobes() !== F0)
      $display("FAIL add_return state=%0d strobes=%b required state=0 strobes=%b",
               cs_if.state, strobes(), F0);
    else npass++;
  endtask

  task automatic test_ld_st();
    logic [25:0] exp_ld [8];
    logic [25:0] exp_st [8];
    exp_ld = '{F0, F1, F2, B_GRB | B_BAOUT | B_RYI, B_CSO | B_RZI, B_RZO | B_MARI,
               B_MRD | B_MDRI, B_MDRO | B_GRA | B_RIN};
    exp_st = '{F0, F1, F2, B_GRB | B_BAOUT | B_RYI, B_CSO | B_RZI, B_RZO | B_MARI,
               B_GRA | B_ROUT | B_MDRI, B_MWR};
    restart();
    cs_if.ir = 32'h0012_3456;
    for (int unsigned i = 0; i < 8; i++) begin
      ntotal++;
      if (cs_if.state !== 4'(i) || strobes() !== exp_ld[i])
        $display("FAIL ld_t%0d state=%0d strobes=%b required state=%0d strobes=%b",
                 i, cs_if.state, strobes(), i, exp_ld[i]);
      else npass++;
      tick();
    end
    ntotal++;
    if (cs_if.state !== 4'd0)
      $display("FAIL ld_return state=%0d required 0", cs_if.state);
    else npass++;

    cs_if.ir = 32'h1765_4321;
    for (int unsigned i = 0; i < 8; i++) begin
      ntotal++;
      if (cs_if.state !== 4'(i) || strobes() !== exp_st[i])
        $display("FAIL st_t%0d state=%0d strobes=%b required state=%0d strobes=%b",
                 i, cs_if.state, strobes(), i, exp_st[i]);
      else npass++;
      tick();
    end
    ntotal++;
    if (cs_if.state !== 4'd0)
      $display("FAIL st_return state=%0d required 0", cs_if.state);
    else npass++;
  endtask

  task automatic test_addi_ldi();
    logic [31:0] irs [2];
    logic [25:0] exp3 [2];
    irs  = '{32'h6000_00FF, 32'h0800_0010};
    exp3 = '{B_GRB | B_ROUT | B_RYI, B_GRB | B_BAOUT | B_RYI};
    for (int unsigned k = 0; k < 2; k++) begin
      restart();
      cs_if.ir = irs[k];
      for (int unsigned i = 0; i < 3; i++) tick();
      ntotal++;
      if (cs_if.state !== 4'd3 || strobes() !== exp3[k])
        $display("FAIL imm%0d_t3 state=%0d strobes=%b required state=3 strobes=%b",
                 k, cs_if.state, strobes(), exp3[k]);
      else npass++;
      tick();
      ntotal++;
      if (cs_if.state !== 4'd4 || strobes() !== (B_CSO | B_RZI))
        $display("FAIL imm%0d_t4 state=%0d strobes=%b required state=4 strobes=%b",
                 k, cs_if.state, strobes(), B_CSO | B_RZI);
      else npass++;
      tick();
      ntotal++;
      if (cs_if.state !== 4'd5 || strobes() !== (B_GRA | B_RIN | B_RZO))
        $display("FAIL imm%0d_t5 state=%0d strobes=%b required state=5 strobes=%b",
                 k, cs_if.state, strobes(), B_GRA | B_RIN | B_RZO);
      else npass++;
      tick();
      ntotal++;
      if (cs_if.state !== 4'd0)
        $display("FAIL imm%0d_return state=%0d required 0", k, cs_if.state);
      else npass++;
    end
  endtask

  task automatic test_halt();
    int unsigned bad;
    restart();
    cs_if.ir = 32'hD800_0000;
    for (int unsigned i = 0; i < 3; i++) tick();
    ntotal++;
    if (cs_if.state !== 4'd3 || strobes() !== 26'd0)
      $display("FAIL halt_t3 state=%0d strobes=%b required state=3 strobes=0",
               cs_if.state, strobes());
    else npass++;
    tick();
    ntotal++;
    if (cs_if.state !== 4'd8 || cs_if.run !== 1'b0)
      $display("FAIL halt_enter state=%0d run=%b required state=8 run=0", cs_if.state, cs_if.run);
    else npass++;
    bad = 0;
    cs_if.ir = 32'h1800_0000;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      if (cs_if.state !== 4'd8 || cs_if.run !== 1'b0 || strobes() !== 26'd0) bad++;
    end
    ntotal++;
    if (bad !== 0)
      $display("FAIL halt_hold bad_cycles=%0d required 0", bad);
    else npass++;
    clear = 1'b1;
    #1;
    ntotal++;
    if (cs_if.state !== 4'd0 || cs_if.run !== 1'b1)
      $display("FAIL halt_clear state=%0d run=%b required state=0 run=1", cs_if.state, cs_if.run);
    else npass++;
    clear = 1'b0;
    #1;
  endtask

  task automatic test_unknown();
    restart();
    cs_if.ir = 32'hF800_0000;
    for (int unsigned i = 0; i < 3; i++) tick();
    ntotal++;
    if (cs_if.state !== 4'd3 || strobes() !== 26'd0)
      $display("FAIL unknown_t3 state=%0d strobes=%b required state=3 strobes=0",
               cs_if.state, strobes());
    else npass++;
    tick();
    ntotal++;
    if (cs_if.state !== 4'd0 || strobes() !== F0)
      $display("FAIL unknown_return state=%0d strobes=%b required state=0 strobes=%b",
               cs_if.state, strobes(), F0);
    else npass++;
    cs_if.ir = 32'hD000_0000;
    for (int unsigned i = 0; i < 4; i++) tick();
    ntotal++;
    if (cs_if.state !== 4'd0)
      $display("FAIL nop_return state=%0d required 0", cs_if.state);
    else npass++;
  endtask

  task automatic test_random();
    logic [4:0]  opc;
    int unsigned exp_len, cyc, bad_oh, bad_len;
    logic [4:0]  drv;
    restart();
    bad_oh  = 0;
    bad_len = 0;
    for (int unsigned n = 0; n < 1000; n++) begin
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'b11011) opc = 5'b11010;
      cs_if.ir = {opc, 27'($urandom)};
      case (opc)
        5'b00000, 5'b00010: exp_len = 8;
        5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100: exp_len = 6;
        default: exp_len = 4;
      endcase
      cyc = 0;
      do begin
        drv = {cs_if.pco, cs_if.mdro, cs_if.rzo, cs_if.csigno, cs_if.rout | cs_if.baout};
        if (!$onehot0(drv) || !$onehot0({cs_if.gra, cs_if.grb, cs_if.grc}) ||
            (cs_if.mem_read && cs_if.mem_write)) bad_oh++;
        tick();
        cyc++;
      end while (cs_if.state !== 4'd0 && cyc < 12);
      if (cyc != exp_len) begin
        if (bad_len == 0)
          $display("FAIL random_latency opcode=%b cycles=%0d required %0d", opc, cyc, exp_len);
        bad_len++;
      end
    end
    ntotal++;
    if (bad_oh !== 0)
      $display("FAIL random_onehot violations=%0d required 0", bad_oh);
    else npass++;
    ntotal++;
    if (bad_len !== 0)
      $display("FAIL random_latency_total wrong=%0d required 0", bad_len);
    else npass++;
  endtask

  initial begin
    clear    = 1'b1;
    cs_if.ir = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_add();
    test_ld_st();
    test_addi_ldi();
    test_halt();
    test_unknown();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
